// File: rtl/axioma_timer_pkg.sv
// Shared timer-subsystem definitions: prescaler select encodings, counter width, tap masks.
package axioma_timer_pkg;

    localparam int PRESC_W = 10;

    typedef enum logic [2:0] {
        PRESCALE_STOP     = 3'd0,
        PRESCALE_DIV1     = 3'd1,
        PRESCALE_DIV8     = 3'd2,
        PRESCALE_DIV64    = 3'd3,
        PRESCALE_DIV256   = 3'd4,
        PRESCALE_DIV1024  = 3'd5,
        PRESCALE_EXT_FALL = 3'd6,
        PRESCALE_EXT_RISE = 3'd7
    } prescale_sel_e;

    localparam logic [PRESC_W-1:0] TAP_MASK_DIV8    = 10'h007;
    localparam logic [PRESC_W-1:0] TAP_MASK_DIV64   = 10'h03F;
    localparam logic [PRESC_W-1:0] TAP_MASK_DIV256  = 10'h0FF;
    localparam logic [PRESC_W-1:0] TAP_MASK_DIV1024 = 10'h3FF;

    // A /N tap fires on the last count of each N-long window (low bits all ones).
    function automatic logic tap_match(input logic [PRESC_W-1:0] cnt,
                                       input logic [PRESC_W-1:0] mask);
        return (cnt & mask) == mask;
    endfunction

endpackage

// File: rtl/axioma_prescaler_mc_if.sv
// Select/control inputs and tick/count outputs of the shared multi-channel prescaler.
interface axioma_prescaler_mc_if
    import axioma_timer_pkg::*;
#(
    parameter int NUM_CH = 2
);
    logic [3*NUM_CH-1:0] prescale_select;
    logic [NUM_CH-1:0]   ext_clk_in;
    logic                psr_clear;
    logic                psr_hold;
    logic [NUM_CH-1:0]   timer_tick;
    logic [PRESC_W-1:0]  presc_count;

    modport master (
        output prescale_select, ext_clk_in, psr_clear, psr_hold,
        input  timer_tick, presc_count
    );

    modport slave (
        input  prescale_select, ext_clk_in, psr_clear, psr_hold,
        output timer_tick, presc_count
    );
endinterface

// File: rtl/axioma_ext_clk_sync.sv
// Synchronises one asynchronous Tn pin and produces single-cycle rise/fall pulses.
// Latency: edge pulse valid SYNC_STAGES clocks after the first sampling edge.
// Backpressure: none; pulses narrower than one clock may be lost.
module axioma_ext_clk_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ext_clk_in,
    output logic ext_rise,
    output logic ext_fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ext_clk_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign ext_rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign ext_fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/axioma_prescaler_mc.sv
// Shared 10-bit prescaler feeding NUM_CH per-channel tap muxes (stop, /1../1024, ext edges).
// Latency: registered tick one clock after tap match; ext pin-to-tick SYNC_STAGES+1 clocks.
// Backpressure: none; ticks are free-running one-cycle count enables.
module axioma_prescaler_mc
    import axioma_timer_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                SYNC_STAGES = 2,
    parameter logic [NUM_CH-1:0] EXT_EN      = {NUM_CH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axioma_prescaler_mc_if.slave  bus
);
    logic [PRESC_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0]  tick_q, tick_d;
    logic [NUM_CH-1:0]  ext_rise, ext_fall;
    logic               clr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ext
        axioma_ext_clk_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk        (clk),
            .reset_n    (reset_n),
            .ext_clk_in (bus.ext_clk_in[g]),
            .ext_rise   (ext_rise[g]),
            .ext_fall   (ext_fall[g])
        );
    end

    always_comb begin
        clr     = bus.psr_clear | bus.psr_hold;
        count_d = clr ? '0 : count_q + 1'b1;
        tick_d  = '0;
        // Counter taps are masked by clear/hold; /1 and external edges bypass the counter.
        for (int i = 0; i < NUM_CH; i++) begin
            case (prescale_sel_e'(bus.prescale_select[3*i +: 3]))
                PRESCALE_STOP:     tick_d[i] = 1'b0;
                PRESCALE_DIV1:     tick_d[i] = 1'b1;
                PRESCALE_DIV8:     tick_d[i] = ~clr & tap_match(count_q, TAP_MASK_DIV8);
                PRESCALE_DIV64:    tick_d[i] = ~clr & tap_match(count_q, TAP_MASK_DIV64);
                PRESCALE_DIV256:   tick_d[i] = ~clr & tap_match(count_q, TAP_MASK_DIV256);
                PRESCALE_DIV1024:  tick_d[i] = ~clr & tap_match(count_q, TAP_MASK_DIV1024);
                PRESCALE_EXT_FALL: tick_d[i] = EXT_EN[i] & ext_fall[i];
                PRESCALE_EXT_RISE: tick_d[i] = EXT_EN[i] & ext_rise[i];
                default:           tick_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tick_q  <= '0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.timer_tick  = tick_q;
    assign bus.presc_count = count_q;

endmodule

// File: doc/axioma_prescaler_mc.md
Name: axioma_prescaler_mc

Overview:
- Multi-channel shared prescaler for the timer subsystem. Successor to the single-channel per-timer prescaler.
- One free-running 10-bit prescale counter is shared by NUM_CH timer channels, as in the ATmega328P shared Timer0/Timer1 prescaler.
- Each channel selects its own tap: stop, /1, /8, /64, /256, /1024, external falling, external rising.
- Adds three features: synchronised external clock inputs (T0/T1 pins), prescaler clear, and hold, with semantics matching GTCCR PSRSYNC/TSM.

Parameters:
NUM_CH, 2, number of timer channels served (1..4)
SYNC_STAGES, 2, synchroniser flops on each external clock pin (2..3)
EXT_EN, 2'b11, per-channel bitmask; bit i=0 makes ext modes on channel i behave as stop

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
prescale_select  in  3*NUM_CH  channel i select in bits [3i+2:3i]; encoding 0 stop, 1 /1, 2 /8, 3 /64, 4 /256, 5 /1024, 6 ext fall, 7 ext rise
ext_clk_in  in  NUM_CH  raw asynchronous Tn pin per channel
psr_clear  in  1  single-cycle request to clear shared counter (PSRSYNC)
psr_hold  in  1  level; holds shared counter at 0 while high (TSM)
timer_tick  out  NUM_CH  registered one-cycle count-enable per channel
presc_count  out  10  current shared counter value (debug/observability)

Behaviour:
- Reset (async, reset_n low): presc_count=0, timer_tick=0, all synchroniser and edge flops=0.
- Shared counter, per rising clk:
  - psr_clear or psr_hold high: counter <= 0.
  - Otherwise counter <= counter+1, wrapping 1023->0.
  - Counter runs regardless of any channel's select.
- Prescaled tap match (combinational): /N matches when counter[log2N-1:0] is all ones (N=8,64,256,1024), evaluated on the pre-increment value.
- While psr_clear or psr_hold is high, no prescaled tap matches in that cycle.
- timer_tick[i] is registered, high for exactly one cycle:
  - stop: 0.
  - /1: 1 every cycle while selected. Unaffected by psr_clear/psr_hold.
  - /N: 1 on the cycle after a match. Period exactly N clocks in steady state. First tick after counter clear comes N clocks after the first increment.
  - ext: source is the synchronised pin, bypassing the counter, so unaffected by psr_clear/psr_hold.
- Select change: takes effect on the next edge. The shared counter is NOT reset, so the first tick after a change can come early; this matches AVR behaviour.
- External path, per channel:
  - SYNC_STAGES flops, then a previous-value flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - tick registered one cycle later. Pin-to-tick latency is SYNC_STAGES+1 clocks from the first clk edge that samples the new level.
  - Synchroniser flops run continuously regardless of select, so switching into an ext mode does not generate a spurious edge unless the pin actually toggles.
  - Pin pulses shorter than one clk period may be lost; this is allowed.
  - Max ext frequency is clk/2.5; higher rates are undefined.
- Simultaneous psr_clear and match on the same cycle: clear wins, no tick.
- psr_hold deasserting: counting resumes from 0 on the next edge.
- Reset mid-operation clears everything immediately; there is no pending tick after release.
- Channels are fully independent except for the shared counter.

Decomposition:
- Shared package axioma_timer_pkg holds:
  - select encodings PRESCALE_STOP..PRESCALE_EXT_RISE (3-bit);
  - PRESC_W=10;
  - tap mask constants for /8, /64, /256, /1024.
- One sub-module axioma_ext_clk_sync (parameter SYNC_STAGES): async pin in -> rise/fall pulses. Instantiated NUM_CH times in a generate loop.
- Counter and tick muxes stay in the top module.

Test Plan:
- Reset with all selects=1 (/1) -> timer_tick=0 during reset; 2'b11 every cycle after reset_n rises; presc_count increments 0,1,2...
- ch0=/8, ch1=/64 from reset -> ch0 ticks at cycles 8,16,24...; ch1 at 64,128; exactly 8 ch0 ticks per ch1 tick over 1024 cycles.
- ch0=/1024, pulse psr_clear at presc_count=500 -> presc_count=0 next cycle; next ch0 tick 1024 cycles after clear; psr_clear coincident with count 1023 -> no tick.
- psr_hold high 100 cycles with ch0=/8, ch1=/1 -> presc_count stays 0, ch0 silent, ch1 ticks every cycle; after release ch0 ticks 8 cycles later.
- ch0=ext rise, toggle ext_clk_in[0] with period 10 clk -> one tick per rising edge, 3 clk after first sampling edge (SYNC_STAGES=2); switch to ext fall -> ticks move to falling edges, no spurious tick at switch.
- EXT_EN=2'b01, ch1=ext rise with toggling pin -> timer_tick[1] stays 0; assert reset_n low mid-stream -> all outputs 0 asynchronously.
